fwd_hazard_unit: RTL
====================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the integer pipeline; generalises the fixed MEM/WB forwarding scheme.
//  Keeps its own shadow copy of in-flight destinations for EXE and DEPTH later stages.
//  Per EXE source it outputs the nearest-stage forward select, and from ID-stage sources it raises a load-use stall.
//  Sits beside the ID/EXE pipeline registers; its outputs drive the EXE operand muxes and the ID/IF hold logic.
// PARAMETERS
//  REG_ADDR_W  5  register-file address width (REG_FILE_ADDR_LEN)
//  NUM_SRC     3  source operands per instruction (val1, val2, store value)
//  DEPTH       2  forwarding stages after EXE (1=MEM, 2=WB, ...); DEPTH>=1
//  LOAD_LAT    2  first stage index at which load data can be forwarded; 1<=LOAD_LAT<=DEPTH
//  ZERO_REG    1  1: register 0 is hardwired; never forwarded and never stalls
//  SEL_W       $clog2(DEPTH+1)  width of one forward select (derived localparam)
// PORTS
//  clk          in   1                  pipeline clock
//  rst_n        in   1                  asynchronous active-low reset
//  flush        in   1                  sync: invalidate all shadow stages
//  id_valid     in   1                  ID holds a real instruction
//  id_src       in   NUM_SRC*REG_ADDR_W ID source regs, src i at [i*REG_ADDR_W +: REG_ADDR_W]
//  id_src_used  in   NUM_SRC            per-source "operand actually read" flag
//  id_dest      in   REG_ADDR_W         ID destination reg
//  id_wb_en     in   1                  ID instruction writes the register file
//  id_is_load   in   1                  ID instruction is a load
//  stall        out  1                  hold IF/ID, insert bubble into EXE
//  fwd_sel      out  NUM_SRC*SEL_W      per EXE source: 0=regfile, k=forward from stage k
//  stall_cnt    out  16                 saturating count of stall cycles
// BEHAVIOUR
//  Shadow stage s (0=EXE..DEPTH): {valid, wb_en, is_load, dest}; stage 0 also keeps src[] and used[].
//  Clocked on every cycle (no global enable):
//   - for k=1..DEPTH: stage[k] <= stage[k-1]
//   - stage[0] <= ID fields with valid=id_valid, unless stall or flush, in which case stage[0].valid<=0 (bubble)
//   - flush: every stage's valid <= 0 next cycle; flush has priority over stall
//  A "producer" at stage s means valid & wb_en & dest==src, and (ZERO_REG=0 or src!=0).
//  fwd_sel[i] is combinational from registered state only (0 latency after the clock edge):
//   - smallest k in 1..DEPTH with a producer for stage0.src[i]; 0 if none, if !stage0.valid, or if !used[i]
//   - the nearest stage wins when several stages match (youngest value)
//  stall is combinational:
//   - set when id_valid, some used source i, and a producer at stage j (0..DEPTH) with is_load, and j+1 < LOAD_LAT
//   - forced to 0 while flush=1 or rst_n=0
//   - a multi-cycle stall arises naturally as the load advances; no extra counter
//  Invariant (assert): never fwd_sel[i]=k with k<LOAD_LAT when stage k is a load producer.
//  stall_cnt: +1 on each clock with stall=1; saturates at 16'hFFFF; not cleared by flush.
//  Async reset: all valid bits 0, all stored fields 0, stall_cnt 0.
//   Outputs during and after reset: stall=0, fwd_sel=0.
//  Reset mid-stall drops stall in the same cycle (no pending state is kept).
//  id_dest==id_src within one instruction: no self-dependency is checked.
// TESTING
//  1 add r3 then add r4=r3+r1 back-to-back, DEPTH=2 -> next cycle fwd_sel[0]=1, fwd_sel[1]=0, stall=0
//  2 producer r3, one unrelated instr, then consumer of r3 -> fwd_sel[0]=2; r3 written in both MEM and WB -> sel=1 (nearest wins)
//  3 lw r5, then add r6=r5+r2 (LOAD_LAT=2) -> stall=1 for exactly 1 cycle, bubble in EXE, then fwd_sel[0]=2
//     repeat with LOAD_LAT=DEPTH=3 -> 2 stall cycles, then fwd_sel[0]=3
//  4 producer writes r0, consumer reads r0, ZERO_REG=1 -> fwd_sel=0, no stall
//     lw r0 followed by a reader of r0 -> no stall
//  5 flush asserted during a load-use stall -> stall=0 that cycle; next cycle all valid=0, fwd_sel=0
//     stall_cnt keeps its value across the flush
//  6 rst_n low mid-stall, and 70000 forced stall cycles
//     -> outputs 0 immediately on reset; stall_cnt saturates at 16'hFFFF

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EXE operand forward selects plus ID load-use stall, tracking in-flight destinations itself
// Latency: fwd_sel and stall are combinational (0 cycles) from the shadow stages and the ID inputs
// Backpressure: stall holds IF/ID and turns the EXE slot into a bubble; flush overrides stall
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 2,
  parameter int LOAD_LAT   = 2,
  parameter int ZERO_REG   = 1,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_wb_en,
  input  logic                          id_is_load,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [15:0]                   stall_cnt
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  // Shadow stages: index 0 is EXE, index k is k stages past EXE.
  logic               st_valid [DEPTH+1];
  logic               st_wb_en [DEPTH+1];
  logic               st_load  [DEPTH+1];
  reg_t               st_dest  [DEPTH+1];
  // Operand info of the instruction currently in EXE.
  reg_t               ex_src   [NUM_SRC];
  logic [NUM_SRC-1:0] ex_used;
  logic               stall_hit;

  // Stage s will write register src; a hardwired r0 never counts as written.
  function automatic logic producer(input int s, input reg_t src);
    return st_valid[s] && st_wb_en[s] && (st_dest[s] == src) &&
           ((ZERO_REG == 0) || (src != '0));
  endfunction

  // Load-use check: the ID instruction would reach EXE before the load's data is forwardable.
  always_comb begin
    stall_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j <= DEPTH; j++) begin
        if (id_src_used[i] && (j + 1 < LOAD_LAT) && st_load[j] &&
            producer(j, id_src[i*REG_ADDR_W +: REG_ADDR_W]))
          stall_hit = 1'b1;
      end
    end
    stall = id_valid && stall_hit && !flush && rst_n;
  end

  // Forward select per EXE source: scanning oldest to youngest lets the nearest stage win.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (st_valid[0] && ex_used[i] && producer(k, ex_src[i]))
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
      end
    end
  end

  // Shadow pipeline: capture ID into EXE (bubble on stall/flush), shift the rest down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= DEPTH; s++) begin
        st_valid[s] <= 1'b0;
        st_wb_en[s] <= 1'b0;
        st_load[s]  <= 1'b0;
        st_dest[s]  <= '0;
      end
      for (int i = 0; i < NUM_SRC; i++) ex_src[i] <= '0;
      ex_used <= '0;
    end else begin
      st_valid[0] <= id_valid && !stall && !flush;
      st_wb_en[0] <= id_wb_en;
      st_load[0]  <= id_is_load;
      st_dest[0]  <= id_dest;
      for (int i = 0; i < NUM_SRC; i++) ex_src[i] <= id_src[i*REG_ADDR_W +: REG_ADDR_W];
      ex_used <= id_src_used;
      for (int k = 1; k <= DEPTH; k++) begin
        st_valid[k] <= st_valid[k-1] && !flush;
        st_wb_en[k] <= st_wb_en[k-1];
        st_load[k]  <= st_load[k-1];
        st_dest[k]  <= st_dest[k-1];
      end
    end
  end

  // Saturating stall-cycle counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  // A load that has not yet reached LOAD_LAT must never be chosen as a forward source.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (k < LOAD_LAT)
            assert (!((fwd_sel[i*SEL_W +: SEL_W] == SEL_W'(k)) && st_load[k] &&
                      producer(k, ex_src[i])));
        end
      end
    end
  end

endmodule
